// File: rtl/sie_tx_arbiter.sv
// Round-robin transmit arbiter sharing one SIE transmitter among three requesters.
// Optional WAIT_RDY abort is compiled in with `define SIE_TX_ARB_TIMEOUT_EN.
module sie_tx_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [3:0] pid0,
    input  logic [3:0] pid1,
    input  logic [3:0] pid2,
    input  logic [2:0] reqEn,
    input  logic       sendPacketRdy,
    output logic       sendPacketWEn,
    output logic [3:0] sendPacketPID,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       timeoutErr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT_RDY,
        DONE
    } arbStateT;

    arbStateT   state;
    logic [1:0] lastGrant;
    logic [1:0] owner;
    logic [2:0] eligible;
    logic       anyEligible;
    logic [1:0] winner;
    logic [3:0] winnerPid;
    logic       timeoutHit;

    function automatic logic [1:0] nextIdx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order is lastGrant+1, lastGrant+2, then lastGrant itself.
    always_comb begin
        logic [1:0] cand1;
        logic [1:0] cand2;
        // NOTE: every variable of this block gets a default first so no latch is inferred.
        cand1       = nextIdx(lastGrant);
        cand2       = nextIdx(cand1);
        eligible    = req & reqEn;
        anyEligible = |eligible;
        winner      = lastGrant;
        if (eligible[cand1]) begin
            winner = cand1;
        end else if (eligible[cand2]) begin
            winner = cand2;
        end
        case (winner)
            2'd0:    winnerPid = pid0;
            2'd1:    winnerPid = pid1;
            default: winnerPid = pid2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sendPacketWEn <= 1'b0;
            sendPacketPID <= 4'h0;
            grant         <= 3'b000;
            done          <= 3'b000;
            busy          <= 1'b0;
            lastGrant     <= 2'd2;
            owner         <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            case (state)
                IDLE: begin
                    if (sendPacketRdy && anyEligible) begin
                        state         <= ISSUE;
                        grant         <= 3'b001 << winner;
                        owner         <= winner;
                        sendPacketPID <= winnerPid;
                        busy          <= 1'b1;
                    end
                end
                ISSUE: begin
                    state         <= SETTLE;
                    sendPacketWEn <= 1'b1;
                end
                SETTLE: begin
                    // Ready is still stale from before the strobe, so it is not looked at here.
                    state         <= WAIT_RDY;
                    sendPacketWEn <= 1'b0;
                end
                WAIT_RDY: begin
                    if (sendPacketRdy || timeoutHit) begin
                        state <= DONE;
                        done  <= grant;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 3'b000;
                    grant     <= 3'b000;
                    busy      <= 1'b0;
                    lastGrant <= owner;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SIE_TX_ARB_TIMEOUT_EN
    logic [7:0] waitCnt;

    assign timeoutHit = ({1'b0, waitCnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= 8'd0;
        end else if (state == SETTLE) begin
            waitCnt <= 8'd0;
        end else if (state == WAIT_RDY && !sendPacketRdy) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    // A ready arriving in the abort cycle wins, so the error is qualified by !sendPacketRdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeoutErr <= 1'b0;
        end else begin
            timeoutErr <= (state == WAIT_RDY) && !sendPacketRdy && timeoutHit;
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign timeoutHit    = 1'b0;
    assign timeoutErr    = 1'b0;
`endif

endmodule
